// File: rtl/cdc_array_settle.sv
// Coherency qualifier for a per-bit CDC synchronizer: dout only moves to a word
// seen unchanged for STABLE_CYCLES samples. Optional restart counter: CDC_ARRAY_SETTLE_STATS_EN.
module cdc_array_settle #(
  parameter int               WIDTH         = 2,
  parameter int               STABLE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             update,
  output logic             busy,
  output logic [15:0]      restart_cnt
);

  localparam int            CW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    SETTLING = 1'b1
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] cand;
  logic [CW-1:0]    cnt;

  // Valid/ready is not used here: din is a level, update is a one-cycle strobe
  // raised in the first cycle dout holds the newly committed word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s      <= RESET_VALUE;
      cand   <= RESET_VALUE;
      cnt    <= '0;
      state  <= IDLE;
      dout   <= RESET_VALUE;
      update <= 1'b0;
      busy   <= 1'b0;
    end else begin
      s      <= din;
      update <= 1'b0;
      case (state)
        IDLE: begin
          if (s != dout) begin
            cand  <= s;
            cnt   <= CW'(1);
            state <= SETTLING;
            busy  <= 1'b1;
          end
        end
        SETTLING: begin
          if (s == dout) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (s != cand) begin
            cand <= s;
            cnt  <= CW'(1);
          end else if (cnt == LAST) begin
            dout   <= cand;
            update <= 1'b1;
            cnt    <= '0;
            state  <= IDLE;
            busy   <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CDC_ARRAY_SETTLE_STATS_EN
  logic [15:0] rc;
  logic        rc_event;

  // Abort (word returned to dout) or restart (word moved to another value).
  assign rc_event = (state == SETTLING) && ((s == dout) || (s != cand));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc <= '0;
    end else if (rc_event && (rc != 16'hFFFF)) begin
      rc <= rc + 16'd1;
    end
  end

  assign restart_cnt = rc;
`else
  assign restart_cnt = '0;
`endif

endmodule
